regfile_sb: RTL
===============

# regfile_sb

Parametrised successor to the 16×32 three-read-port register file, with reset, same-cycle write-to-read bypass, dedicated PC and link write ports, and a pending-write scoreboard. It sits between ID (read and issue), WB (result writeback) and IF (PC update). It supplies operands, the PC and per-port hazard flags to the pipeline hazard unit.

## Interface
Parameters
- DATA_W, 32, register width in bits
- NREGS, 16, number of registers; power of two, ≥4
- ADDR_W, $clog2(NREGS), register index width
- N_RD, 3, number of read ports
- LINK_IDX, 14, index written by the link port
- PC_IDX, NREGS-1, index of the program counter register
- RESET_PC, 0, PC value after reset

Ports
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- wb_en  in  1  general writeback enable
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback data
- lnk_en  in  1  branch-and-link write to LINK_IDX
- lnk_data  in  DATA_W  return address (PC+4)
- pc_en  in  1  PC update enable from IF
- pc_in  in  DATA_W  next PC
- iss_en  in  1  instruction issue with a register destination
- iss_addr  in  ADDR_W  issued destination
- rd_addr  in  N_RD*ADDR_W  read indices; port i uses slice i
- rd_data  out  N_RD*DATA_W  read data; port i uses slice i
- rd_busy  out  N_RD  port i operand has an unresolved pending write
- pc_out  out  DATA_W  current PC (register PC_IDX)
- busy_vec  out  NREGS  scoreboard contents

## Operation
- Storage: NREGS registers of DATA_W bits. Reset sets all registers to 0, except PC_IDX, which is set to RESET_PC. Reset also clears busy_vec to 0.
- Write priority per register per edge:
  - PC_IDX: wb write > pc_en.
  - LINK_IDX: lnk_en > wb write.
  - Other registers: wb write only.
  - The losing write is dropped.
- Read port i is combinational:
  - Default: rd_data[i] = reg[rd_addr[i]].
  - Bypass: when a write to that index is effective this cycle (after the priority rules above), rd_data[i] returns the winning write data instead.
  - Bypass covers all three write sources.
- pc_out is the registered value of PC_IDX. It is not bypassed.
- Scoreboard, per register r on each edge:
  - Set when iss_en and iss_addr == r.
  - Clear when wb_en and wb_addr == r.
  - Set and clear of the same r in one cycle: set wins, because a new producer is outstanding.
  - iss_en to PC_IDX is ignored; the PC bit is never set.
  - lnk_en and pc_en do not touch the scoreboard.
- rd_busy[i] = busy_vec[rd_addr[i]] AND NOT (wb_en AND wb_addr == rd_addr[i]). A same-cycle writeback resolves the hazard through the bypass path.
- Duplicate issue to an already-busy register: the bit stays set. There is no counting; the first writeback clears it.

## Timing
- Write latency is one edge. The register value is visible on rd_data in the same cycle through the bypass, and from the register array from the next cycle.
- pc_out updates one edge after pc_en.
- busy_vec updates one edge after iss_en or wb_en. rd_busy is combinational from busy_vec, rd_addr and the wb inputs.
- Reset asserted mid-cycle: outputs take reset values without waiting for a clock edge:
  - rd_data reflects zeroed registers, modulo the bypass of inputs still driven.
  - pc_out = RESET_PC.
  - busy_vec = 0 and rd_busy = 0.
- Writes presented during reset are lost. The first write is taken on the first rising edge after reset deasserts.
- No X on any output after reset for any legal input.

## Test plan
- Reset: drive reset=1 with clock idle, pc_in=32'hDEAD0000, pc_en=1 → pc_out=0 and busy_vec=0 immediately; all read ports return 0.
- Write then read: write R3=32'h30303030 via wb → rd_data port0 (addr 3) shows 32'h30303030 in the same cycle (bypass) and after the edge (array). A read of R4 stays 0.
- Link priority: lnk_en=1 with lnk_data=32'h00000104, and in the same cycle wb_en to R14 with 32'hE0E0E0E0 → R14 = 32'h00000104; all N_RD ports reading 14 see 32'h00000104 pre-edge.
- PC priority: pc_en with pc_in=32'h00000008, and wb to R15 with 32'h00000040 in the same cycle → pc_out=32'h00000040 after the edge. The next pc_en with 32'h00000044 → pc_out=32'h00000044.
- Scoreboard:
  - Issue R5 → busy_vec[5]=1 next cycle, and rd_busy=1 for a port reading R5.
  - When wb R5 (32'h55) is presented → rd_busy drops the same cycle and rd_data=32'h55.
  - Next cycle → busy_vec[5]=0.
  - Simultaneous issue R5 and wb R5 → busy_vec[5] stays 1.
- Parameter sweep: DATA_W=16, NREGS=8, N_RD=2, RESET_PC=16'h0100. Repeat the cases above with LINK_IDX=6 and PC_IDX=7 → identical behaviour at the narrower widths; pc_out=16'h0100 after reset.

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass, dedicated PC and link
// write ports, and a pending-write scoreboard for the hazard unit.
module regfile_sb #(
  parameter int                DATA_W   = 32,
  parameter int                NREGS    = 16,
  parameter int                ADDR_W   = $clog2(NREGS),
  parameter int                N_RD     = 3,
  parameter int                LINK_IDX = 14,
  parameter int                PC_IDX   = NREGS - 1,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     lnk_en,
  input  logic [DATA_W-1:0]        lnk_data,
  input  logic                     pc_en,
  input  logic [DATA_W-1:0]        pc_in,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_busy,
  output logic [DATA_W-1:0]        pc_out,
  output logic [NREGS-1:0]         busy_vec
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  wb_dec;
  logic [NREGS-1:0]  iss_dec;
  logic [NREGS-1:0]  we;
  logic [DATA_W-1:0] wd [NREGS];
  logic [NREGS-1:0]  busy_next;

  // One-hot decode of the writeback and issue destinations; the PC can
  // never become busy, so its issue bit is masked here.
  always_comb begin
    wb_dec  = '0;
    iss_dec = '0;
    for (int r = 0; r < NREGS; r++) begin
      wb_dec[r]  = wb_en && (wb_addr == ADDR_W'(r));
      iss_dec[r] = iss_en && (iss_addr == ADDR_W'(r)) && (r != PC_IDX);
    end
  end

  // Per-register winning write after priority resolution. This single
  // result feeds both the array update and the read bypass, so the two
  // can never disagree about which source won.
  always_comb begin
    we = '0;
    for (int r = 0; r < NREGS; r++) begin
      wd[r] = '0;
      if (r == PC_IDX) begin
        if (wb_dec[r]) begin
          we[r] = 1'b1;
          wd[r] = wb_data;
        end else if (pc_en) begin
          we[r] = 1'b1;
          wd[r] = pc_in;
        end
      end else if (r == LINK_IDX) begin
        if (lnk_en) begin
          we[r] = 1'b1;
          wd[r] = lnk_data;
        end else if (wb_dec[r]) begin
          we[r] = 1'b1;
          wd[r] = wb_data;
        end
      end else if (wb_dec[r]) begin
        we[r] = 1'b1;
        wd[r] = wb_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= (r == PC_IDX) ? RESET_PC : '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (we[r]) begin
          regs[r] <= wd[r];
        end
      end
    end
  end

  // Issue beats writeback on the same register: the new producer is still
  // outstanding after the old result lands.
  always_comb begin
    busy_next = (busy_vec & ~wb_dec) | iss_dec;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < N_RD; i++) begin
      a = rd_addr[i*ADDR_W +: ADDR_W];
      rd_data[i*DATA_W +: DATA_W] = we[a] ? wd[a] : regs[a];
      rd_busy[i] = busy_vec[a] & ~wb_dec[a];
    end
  end

  assign pc_out = regs[PC_IDX];

endmodule
